// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: two-requester arbiter for the register file write port
// and flag write port. The grant is combinational, and the write presented
// to the register file is registered one cycle after the grant.
// Optional build macro: RF_ARB_FIXED_PRIO_EN. When it is defined, requester 0
// always wins ties and the round-robin pointer is held at 0.
module rf_write_arbiter #(
  parameter int DW = 8,
  parameter int AW = 3,
  parameter int CW = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          stall,
  input  logic          req0,
  input  logic          req1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] data0,
  input  logic [DW-1:0] data1,
  input  logic          fwe0,
  input  logic          fwe1,
  input  logic          fin0,
  input  logic          fin1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          flag_we,
  output logic          flag_val,
  output logic          last_gnt,
  output logic [CW-1:0] collisions
);

  // Preferred requester when both are requesting (0 or 1).
  logic ptr;

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    if (&v) return v;
    return v + {{(CW-1){1'b0}}, 1'b1};
  endfunction

  // Grant decision: no grant is issued under reset or stall. A lone requester
  // wins. On a tie, the requester selected by ptr wins.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset && !stall) begin
      if (req0 && (!req1 || !ptr)) gnt0 = 1'b1;
      else if (req1)               gnt1 = 1'b1;
    end
  end

`ifdef RF_ARB_FIXED_PRIO_EN
  assign ptr = 1'b0;
`else
  // Round-robin pointer: after a grant, prefer the requester that lost.
  always_ff @(posedge clock) begin
    if (reset)     ptr <= 1'b0;
    else if (gnt0) ptr <= 1'b1;
    else if (gnt1) ptr <= 1'b0;
  end
`endif

  // Remember which requester was granted most recently.
  always_ff @(posedge clock) begin
    if (reset)     last_gnt <= 1'b0;
    else if (gnt0) last_gnt <= 1'b0;
    else if (gnt1) last_gnt <= 1'b1;
  end

  // Collision counter: counts dual-request cycles that are not stalled.
  always_ff @(posedge clock) begin
    if (reset)                       collisions <= '0;
    else if (req0 && req1 && !stall) collisions <= sat_inc(collisions);
  end

  // ---- stage boundary: grant cycle -> register file write cycle ----
  // Capture the granted request. On idle cycles, only the enables drop, and
  // the address, data and flag value keep their last values.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_en    <= 1'b0;
      flag_we  <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      flag_val <= 1'b0;
    end else if (gnt0) begin
      wr_en    <= 1'b1;
      flag_we  <= fwe0;
      wr_addr  <= addr0;
      wr_data  <= data0;
      flag_val <= fin0;
    end else if (gnt1) begin
      wr_en    <= 1'b1;
      flag_we  <= fwe1;
      wr_addr  <= addr1;
      wr_data  <= data1;
      flag_val <= fin1;
    end else begin
      wr_en    <= 1'b0;
      flag_we  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Testbench for rf_write_arbiter. Each directed step carries the grant that is
// expected for it. When a grant is expected, the write it should produce is
// pushed into a queue. A monitor pops that queue whenever the DUT drives
// wr_en. A second instance with CW=2 covers saturation of the counter.
module tb_rf_write_arbiter;
  localparam int DW = 8;
  localparam int AW = 3;
`ifdef RF_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clock, reset, stall;
  logic req0, req1, fwe0, fwe1, fin0, fin1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] data0, data1;
  logic gnt0, gnt1, wr_en, flag_we, flag_val, last_gnt;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [7:0] collisions;
  logic gnt0_s, gnt1_s, wr_en_s, flag_we_s, flag_val_s, last_gnt_s;
  logic [AW-1:0] wr_addr_s;
  logic [DW-1:0] wr_data_s;
  logic [1:0] collisions_s;

  int n_cmp = 0;
  int n_bad = 0;
  // Expected write entry: {addr, data, flag_we, flag_val}.
  logic [AW+DW+1:0] exp_q[$];

  rf_write_arbiter #(.DW(DW), .AW(AW), .CW(8)) dut (
    .clock(clock), .reset(reset), .stall(stall),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .data0(data0), .data1(data1), .fwe0(fwe0), .fwe1(fwe1),
    .fin0(fin0), .fin1(fin1), .gnt0(gnt0), .gnt1(gnt1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .flag_we(flag_we), .flag_val(flag_val), .last_gnt(last_gnt),
    .collisions(collisions));

  rf_write_arbiter #(.DW(DW), .AW(AW), .CW(2)) dut_s (
    .clock(clock), .reset(reset), .stall(stall),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .data0(data0), .data1(data1), .fwe0(fwe0), .fwe1(fwe1),
    .fin0(fin0), .fin1(fin1), .gnt0(gnt0_s), .gnt1(gnt1_s),
    .wr_en(wr_en_s), .wr_addr(wr_addr_s), .wr_data(wr_data_s),
    .flag_we(flag_we_s), .flag_val(flag_val_s), .last_gnt(last_gnt_s),
    .collisions(collisions_s));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Run one cycle. Check the grants against e0/e1 mid-cycle and queue the
  // write that the expected grant should produce.
  task automatic step(input logic e0, input logic e1);
    @(negedge clock);
    chk("gnt0", {31'd0, gnt0}, {31'd0, e0});
    chk("gnt1", {31'd0, gnt1}, {31'd0, e1});
    if (e0) exp_q.push_back({addr0, data0, fwe0, fin0});
    if (e1) exp_q.push_back({addr1, data1, fwe1, fin1});
    @(posedge clock);
    #1;
  endtask

  // Tie cycle: with round-robin, the winner is rr1 ? 1 : 0. With fixed
  // priority, requester 0 always wins.
  task automatic step_tie(input bit rr1);
    if (FIXED || !rr1) step(1'b1, 1'b0);
    else               step(1'b0, 1'b1);
  endtask

  // Monitor: every write the DUT issues must match the oldest queued write.
  initial begin
    logic [AW+DW+1:0] e;
    @(posedge clock);
    forever begin
      @(negedge clock);
      #2;
      if (wr_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {31'd0, wr_en}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("write_tuple", {22'd0, wr_addr, wr_data, flag_we, flag_val}, {22'd0, e});
        end
      end else begin
        chk("idle_flag_we", {31'd0, flag_we}, 32'd0);
      end
    end
  end

  initial begin
    reset = 1'b1; stall = 1'b0;
    req0 = 1'b1; addr0 = 3'd1; data0 = 8'h11; fwe0 = 1'b1; fin0 = 1'b0;
    req1 = 1'b1; addr1 = 3'd2; data1 = 8'h22; fwe1 = 1'b0; fin1 = 1'b1;

    // Reset held for two cycles with both requesting.
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("reset_wr_en", {31'd0, wr_en}, 32'd0);
    chk("reset_collisions", {24'd0, collisions}, 32'd0);
    chk("reset_wr_data", {24'd0, wr_data}, 32'd0);
    reset = 1'b0;

    // Contention: the grants alternate, starting with requester 0.
    step_tie(1'b0);
    step_tie(1'b1);
    step_tie(1'b0);
    step_tie(1'b1);
    chk("collisions_after_4", {24'd0, collisions}, 32'd4);
    step_tie(1'b0);
    chk("collisions_after_5", {24'd0, collisions}, 32'd5);
    chk("collisions_sat_cw2", {30'd0, collisions_s}, 32'd3);

    // Stall: no grants, the counter holds, and the last write still retires.
    stall = 1'b1;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("collisions_stall", {24'd0, collisions}, 32'd5);
    stall = 1'b0;
    step_tie(1'b1);
    chk("collisions_post_stall", {24'd0, collisions}, 32'd6);

    // Single requester 1.
    req0 = 1'b0; addr1 = 3'd5; data1 = 8'hA7; fwe1 = 1'b1; fin1 = 1'b1;
    step(1'b0, 1'b1);
    chk("collisions_single", {24'd0, collisions}, 32'd6);
    req1 = 1'b0;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("hold_wr_addr", {29'd0, wr_addr}, 32'd5);
    chk("hold_wr_data", {24'd0, wr_data}, 32'hA7);
    chk("hold_flag_val", {31'd0, flag_val}, 32'd1);
    chk("last_gnt_1", {31'd0, last_gnt}, 32'd1);

    // Single requester 0. The flag value is captured even when fwe0 is 0.
    req0 = 1'b1; addr0 = 3'd7; data0 = 8'h3C; fwe0 = 1'b0; fin0 = 1'b1;
    step(1'b1, 1'b0);
    req0 = 1'b0;
    step(1'b0, 1'b0);
    chk("last_gnt_0", {31'd0, last_gnt}, 32'd0);

    // Mid-run reset returns the pointer to requester 0.
    reset = 1'b1; req0 = 1'b1; req1 = 1'b1;
    addr0 = 3'd1; data0 = 8'h11; fwe0 = 1'b1; fin0 = 1'b0;
    addr1 = 3'd2; data1 = 8'h22; fwe1 = 1'b0; fin1 = 1'b1;
    step(1'b0, 1'b0);
    reset = 1'b0;
    step(1'b1, 1'b0);
    chk("collisions_after_mid_reset", {24'd0, collisions}, 32'd1);
    step_tie(1'b1);
    req0 = 1'b0; req1 = 1'b0;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("pending_writes", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
